// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU with registered result/flags
// and an iterative shift-and-add multiplier (2*WIDTH product).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand handshake (a, b, func)
//   out_valid/out_ready        result handshake
//   result, result_hi          low/high result (hi only for MUL)
//   cout, zero, neg, ovf       flags
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  localparam logic [WIDTH:0] WL =
    (WIDTH+1)'(WIDTH);
  localparam logic [SHW-1:0] LAST =
    SHW'(WIDTH-1);

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_SHL = 3'd5;
  localparam logic [2:0] F_SHR = 3'd6;
  localparam logic [2:0] F_MUL = 3'd7;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_e;

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic               ov_q, ov_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               c_q, c_d;
  logic               z_q, z_d;
  logic               n_q, n_d;
  logic               v_q, v_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               shbig;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               xfer;
  logic               pop;

  // Ready is gated by rst_n so nothing is
  // accepted while reset is held.
  assign in_ready = rst_n
                  && (state_q == IDLE)
                  && (!ov_q || out_ready);
  assign xfer = in_valid && in_ready;
  assign pop  = ov_q && out_ready;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    shbig   = ({1'b0, b} >= WL);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (1'b1)
      (func == F_ADD): begin
        alu_res = sum[M:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[M] == b[M])
               && (sum[M] != a[M]);
      end
      (func == F_SUB): begin
        alu_res = diff[M:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[M] != b[M])
               && (diff[M] != a[M]);
      end
      (func == F_AND): alu_res = a & b;
      (func == F_OR):  alu_res = a | b;
      (func == F_XOR): alu_res = a ^ b;
      (func == F_SHL):
        alu_res = shbig ? '0
                : (a << b[SHW-1:0]);
      (func == F_SHR):
        alu_res = shbig ? '0
                : (a >> b[SHW-1:0]);
      (func == F_MUL): alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign acc_nx = acc_q
    + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    res_d    = res_q;
    hi_d     = hi_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    if (pop) ov_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (func == F_MUL) begin
            state_d  = MUL_BUSY;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            ov_d  = 1'b1;
            res_d = alu_res;
            hi_d  = '0;
            c_d   = alu_c;
            z_d   = (alu_res == '0);
            n_d   = alu_res[M];
            v_d   = alu_v;
          end
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          ov_d    = 1'b1;
          res_d   = acc_nx[M:0];
          hi_d    = acc_nx[2*WIDTH-1:WIDTH];
          c_d     = 1'b0;
          z_d     = (acc_nx == '0);
          n_d     = acc_nx[M];
          v_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign cout      = c_q;
  assign zero      = z_q;
  assign neg       = n_q;
  assign ovf       = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=8)
// plus a WIDTH=16 multiply instance.
module tb_seq_alu;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   func;
  logic         out_valid, out_ready;
  logic [W-1:0] result, result_hi;
  logic         cout, zero, neg, ovf;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, r16, h16;
  logic [2:0]  f16;
  logic        c16, z16, n16, v16;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .cout(cout), .zero(zero),
    .neg(neg), .ovf(ovf)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .func(f16),
    .out_valid(ov16), .out_ready(or16),
    .result(r16), .result_hi(h16),
    .cout(c16), .zero(z16),
    .neg(n16), .ovf(v16)
  );

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic c, z, n, v;
    int   due;
    bit   seen;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   macc = -100;
  bit   rand_rdy = 1'b0;
  bit   stall_prev = 1'b0;
  logic [19:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic.
  function automatic exp_t model(input int ia,
                                 input int ib,
                                 input int f);
    exp_t e;
    int r, hi, c, v, sa, sb, sr, p;
    r = 0; hi = 0; c = 0; v = 0;
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    case (f)
      0: begin
        r  = (ia + ib) % 256;
        c  = (ia + ib > 255) ? 1 : 0;
        sr = sa + sb;
        v  = (sr > 127 || sr < -128) ? 1 : 0;
      end
      1: begin
        r  = (ia - ib + 256) % 256;
        c  = (ia < ib) ? 1 : 0;
        sr = sa - sb;
        v  = (sr > 127 || sr < -128) ? 1 : 0;
      end
      2: r = ia & ib;
      3: r = ia | ib;
      4: r = ia ^ ib;
      5: r = (ib >= 8) ? 0 : (ia << ib) & 255;
      6: r = (ib >= 8) ? 0 : ia >> ib;
      default: begin
        p  = ia * ib;
        r  = p % 256;
        hi = p / 256;
      end
    endcase
    e.res  = r[7:0];
    e.hi   = hi[7:0];
    e.c    = c[0];
    e.v    = v[0];
    e.z    = (r == 0) && (hi == 0);
    e.n    = (r >= 128);
    e.due  = 0;
    e.seen = 1'b0;
    return e;
  endfunction

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    logic [19:0] pay;
    bit busy;
    exp_t e;
    pay = {result, result_hi,
           cout, zero, neg, ovf};
    if (!rst_n) begin
      q.delete();
      macc = -100;
      stall_prev = 1'b0;
      chk("rst_ready", in_ready, 0);
      chk("rst_outs", {out_valid, pay}, 0);
    end else begin
      busy = (cyc > macc) && (cyc <= macc + W);
      chk("in_ready", in_ready,
          busy ? 1'b0
               : (!out_valid || out_ready));
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", pay, held);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected: out_valid=1 want 0");
        end else begin
          e = q[0];
          if (!e.seen)
            chk("latency", cyc, e.due);
          q[0].seen = 1'b1;
          chk("payload", pay,
              {e.res, e.hi, e.c, e.z, e.n, e.v});
          if (out_ready) void'(q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      held = pay;
      if (in_valid && in_ready) begin
        e = model(a, b, func);
        if (func == 3'd7) begin
          e.due = cyc + W + 1;
          macc  = cyc;
        end else begin
          e.due = cyc + 1;
        end
        q.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy)
        out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Call just after a rising edge; returns
  // just after the edge that transferred.
  task automatic issue(input logic [7:0] ia,
                       input logic [7:0] ib,
                       input logic [2:0] f,
                       output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    func = f;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    func = 3'($urandom);
  endtask

  task automatic wait_out();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: out_valid=0 want 1");
    end
  endtask

  initial begin
    int w, t0;
    bit got;
    logic [2:0] rf;
    logic [7:0] rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; func = '0;
    iv16 = 1'b0; or16 = 1'b1;
    a16 = '0; b16 = '0; f16 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(75, 61, 0, w);
    @(negedge clk);
    chk("t1_add",
        {result, cout, ovf, neg, zero},
        {8'd136, 1'b0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    issue(61, 75, 1, w);
    @(negedge clk);
    chk("t2_sub",
        {result, cout, ovf, neg},
        {8'd242, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    issue(75, 75, 1, w);
    @(negedge clk);
    chk("t2_zero", {result, zero, cout},
        {8'd0, 1'b1, 1'b0});
    @(posedge clk); #1;

    issue(75, 61, 7, w);
    wait_out();
    chk("t3_mul", {result_hi, result},
        16'h11DF);
    @(posedge clk); #1;

    issue(8'h81, 1, 5, w);
    issue(8'h81, 8, 5, w);
    issue(8'h81, 7, 6, w);
    issue(75, 61, 2, w);
    issue(75, 61, 3, w);
    issue(75, 61, 4, w);
    @(negedge clk);
    chk("t4_xor", result, 118);
    @(posedge clk); #1;

    out_ready = 1'b0;
    issue(100, 100, 0, w);
    repeat (5) begin
      @(negedge clk);
      chk("t5_stall_rdy", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(9, 3, 1, w);
    chk("t5_same_cycle", w, 0);
    @(negedge clk);
    chk("t5_new", result, 6);
    @(posedge clk); #1;

    issue(200, 100, 7, w);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async",
        {out_valid, result, result_hi,
         cout, zero, neg, ovf, in_ready}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", in_ready, 1);
    repeat (12) begin
      @(negedge clk);
      chk("t6_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom);
      rb = ($urandom_range(0, 1) != 0)
         ? 8'($urandom_range(0, 10))
         : 8'($urandom);
      issue(8'($urandom), rb, rf, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    chk("drain", q.size(), 0);

    @(posedge clk); #1;
    iv16 = 1'b1;
    a16 = 16'hFFFF;
    b16 = 16'hFFFF;
    f16 = 3'd7;
    got = 1'b0;
    t0 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ir16) begin
        got = 1'b1;
        t0 = cyc;
        break;
      end
    end
    chk("w16_accept", got, 1);
    @(posedge clk);
    #1 iv16 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ov16) begin
        got = 1'b1;
        break;
      end
    end
    chk("w16_valid", got, 1);
    chk("w16_latency", cyc - t0, 17);
    chk("w16_mul", {h16, r16}, 32'hFFFE0001);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
